// File: rtl/nibble_capture_if.sv
// Capture/read bus between nibble_capture and its producer/consumer side.
// The slave modport is the FIFO; the master modport is whoever drives y and drains samples.
interface nibble_capture_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic              enable;
    logic [DATA_W-1:0] y;
    logic              clear;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    modport master (
        output enable, y, clear, rd_en,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  enable, y, clear, rd_en,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/nibble_capture.sv
// Samples the 4-bit y stream into a small FIFO drained by a rd_en/rd_valid handshake.
// Define NIBBLE_CAPTURE_ON_CHANGE_EN to push only samples that differ from the last pushed one.
module nibble_capture #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    nibble_capture_if.slave  bus
);
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              push_req;
    logic              push;
    logic              pop;
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
    logic [DATA_W-1:0] last_q, last_d;
    logic              first_q, first_d;
`endif

    always_comb begin
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
        push_req = bus.enable && (first_q || (bus.y != last_q));
`else
        push_req = bus.enable;
`endif
        pop  = bus.rd_en && !empty_q;
        // A pop on the same edge frees the slot, so a full FIFO can still accept a push.
        push = push_req && (!full_q || pop);

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
        last_d  = last_q;
        first_d = first_q;
`endif

        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
            last_d  = '0;
            first_d = 1'b1;
`endif
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bus.y;
                wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
                last_d  = bus.y;
                first_d = 1'b0;
`endif
            end
            if (pop) begin
                rd_data_d = mem_q[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            end
            rd_valid_d = pop;
            if (push_req && full_q && !pop) begin
                overflow_d = 1'b1;
            end
            count_d = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_COUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
            last_q  <= '0;
            first_q <= 1'b1;
`endif
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
`ifdef NIBBLE_CAPTURE_ON_CHANGE_EN
            last_q  <= last_d;
            first_q <= first_d;
`endif
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
endmodule

// File: doc/nibble_capture.md
Name: nibble_capture

Overview:
- Receive-side companion to the 4-bit `x`/`y` processing block; sits on that block's `y` output.
- Samples `y` on every enabled clock and buffers samples in a small synchronous FIFO.
- A downstream reader (checker, display driver or host logic) drains the FIFO through a read-enable/valid handshake.
- Reports fill level and a sticky overflow flag so lost samples are always visible.

Parameters:
- DATA_W, 4: sample width; matches the `y` bus.
- DEPTH, 8: FIFO entries; power of two, at least 2.
- ADDR_W, 3: pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enable  input  1  capture qualifier; `y` is sampled only while high.
- y  input  DATA_W  sample stream from the processing block.
- clear  input  1  synchronous flush; empties FIFO and clears overflow.
- rd_en  input  1  read request from the consumer.
- rd_data  output  DATA_W  registered head-of-FIFO sample.
- rd_valid  output  1  one-cycle pulse; `rd_data` is valid that cycle.
- empty  output  1  FIFO holds no samples.
- full  output  1  FIFO holds DEPTH samples.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a sample was dropped because the FIFO was full.

Behaviour:
- Reset values (asserted asynchronously, regardless of clk): write pointer 0, read pointer 0, count 0, rd_data 0, rd_valid 0, overflow 0, empty 1, full 0.
- Write condition (push): enable high at a rising edge (further gated by the optional feature).
  - Pushed value is `y` as sampled at that edge.
  - Write pointer increments modulo DEPTH.
- Read condition (pop): rd_en high and empty low at a rising edge.
  - rd_data is loaded with the head entry and rd_valid goes high.
  - Latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid valid from edge N until edge N+1.
  - Read pointer increments modulo DEPTH.
- rd_en while empty: ignored; rd_valid stays 0 and rd_data holds its previous value.
- rd_valid is low in every cycle without a successful pop. rd_data holds its last value.
- Push while full, no pop: sample dropped, overflow set to 1. Pointers and count unchanged.
- Push and pop on the same edge while full: both happen; count stays DEPTH; overflow not set.
- Push and pop on the same edge while empty: push only. There is no fall-through; rd_valid stays 0 and count becomes 1.
- Push and pop on the same edge otherwise: both happen; count unchanged.
- count = pushes − pops. empty = (count == 0); full = (count == DEPTH). All three are registered, with no combinational path from inputs.
- Pointers wrap from DEPTH−1 to 0 with no gap, so ordering is preserved across the wrap.
- clear: has priority over push and pop on the same edge.
  - Pointers 0, count 0, overflow 0, rd_valid 0.
  - rd_data retains its value.
- overflow: cleared only by reset or clear.
- Reset asserted mid-stream: all contents are discarded and the first enabled edge after release writes entry 0.

Optional Feature:
- Macro: `NIBBLE_CAPTURE_ON_CHANGE_EN`.
- Defined:
  - A push occurs only when enable is high and `y` differs from the last pushed value.
  - The first enabled sample after reset or clear is always pushed, tracked by an internal first-sample flag.
  - The last-pushed register resets to 0; clear also resets it to 0.
  - Dropped-because-full samples do not update the last-pushed register.
- Undefined: every enabled edge pushes. Neither the last-pushed register nor the flag exists.

Test Plan:
1. Reset, then enable=1 with y=0,1,2,3 on four edges, then enable=0 and rd_en=1 for 4 cycles -> rd_valid pulses 4 times with rd_data 0,1,2,3; count goes 4→0; empty=1 at end.
2. Enable for 10 edges with y=0..9, no reads -> full=1 after 8 pushes, count=8, overflow=1. Draining returns 0..7, showing 8 and 9 were dropped.
3. FIFO full (count=8), enable=1 and rd_en=1 together for 3 edges -> count stays 8, overflow stays 0, reads return the oldest 3 entries in order.
4. Empty FIFO, enable=1 y=5 and rd_en=1 on the same edge -> no rd_valid, count=1. Next edge rd_en=1 -> rd_data=5, rd_valid=1.
5. Partly full with overflow=1; pulse clear together with enable/rd_en -> count=0, empty=1, overflow=0, no push and no rd_valid. Separately, async reset mid-fill -> all flags at reset values without waiting for a clk edge.
6. `NIBBLE_CAPTURE_ON_CHANGE_EN` defined, y held 0,0,1,1,1,2,0 over 7 enabled edges -> FIFO contains 0,1,2,0 (count=4). Same stimulus with the macro undefined -> count=7.
